// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: clears the 32x32 register file after reset, then arbitrates its single write port
// between pipeline writeback and MUL/DIV results, with a starvation bound and a busy scoreboard.
module rf_write_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WB_VALID,
  input  logic [4:0]  WB_ADDR,
  input  logic [31:0] WB_DATA,
  input  logic        MD_VALID,
  input  logic [4:0]  MD_ADDR,
  input  logic [31:0] MD_DATA,
  output logic        MD_READY,
  input  logic        ISSUE_VALID,
  input  logic [4:0]  ISSUE_ADDR,
  output logic [31:0] BUSY_MASK,
  output logic        RF_WRITE,
  output logic [4:0]  RF_INADDRESS,
  output logic [31:0] RF_IN,
  output logic        PIPE_HOLD,
  output logic        INIT_DONE
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state;
  logic [4:0] clr_cnt;
  logic [1:0] starve;
  logic [31:0] busy, set_mask, clr_mask;
  logic run, wb_eff, md_eff, starved, md_acc, wb_win, md_win;
  always_comb begin
    run = state == RUN;
    wb_eff = WB_VALID && WB_ADDR != 5'd0;
    md_eff = MD_VALID && MD_ADDR != 5'd0;
    starved = starve == 2'd3;
    PIPE_HOLD = !run || starved;
    INIT_DONE = run;
    MD_READY = run && (starved || !wb_eff);
    md_acc = MD_VALID && MD_READY;
    wb_win = !PIPE_HOLD && wb_eff;
    md_win = md_acc && md_eff;
    RF_WRITE = !run || wb_win || md_win;
    RF_INADDRESS = !run ? clr_cnt : wb_win ? WB_ADDR : MD_ADDR;
    RF_IN = !run ? 32'd0 : wb_win ? WB_DATA : MD_DATA;
    set_mask = (run && ISSUE_VALID) ? 32'd1 << ISSUE_ADDR : 32'd0;
    clr_mask = md_acc ? 32'd1 << MD_ADDR : 32'd0;
    BUSY_MASK = busy;
  end
  // set is OR-ed after clear so a same-cycle issue wins; bit 0 is never tracked
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= CLEAR;
      clr_cnt <= 5'd0;
      starve <= 2'd0;
      busy <= 32'd0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~32'd1;
      if (!run) begin
        clr_cnt <= clr_cnt + 5'd1;
        if (clr_cnt == 5'd31) state <= RUN;
      end
      starve <= md_acc ? 2'd0 : (run && MD_VALID && !starved) ? starve + 2'd1 : starve;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed checks of clear sequence, arbitration, starvation bound and scoreboard.
module tb_rf_write_arbiter;
  logic CLK = 0, RESET = 0;
  logic WB_VALID = 0, MD_VALID = 0, ISSUE_VALID = 0;
  logic [4:0] WB_ADDR = 0, MD_ADDR = 0, ISSUE_ADDR = 0;
  logic [31:0] WB_DATA = 0, MD_DATA = 0;
  logic MD_READY, RF_WRITE, PIPE_HOLD, INIT_DONE;
  logic [4:0] RF_INADDRESS;
  logic [31:0] BUSY_MASK, RF_IN;
  int checks = 0, errors = 0;

  rf_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .MD_VALID(MD_VALID), .MD_ADDR(MD_ADDR), .MD_DATA(MD_DATA), .MD_READY(MD_READY),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR), .BUSY_MASK(BUSY_MASK),
    .RF_WRITE(RF_WRITE), .RF_INADDRESS(RF_INADDRESS), .RF_IN(RF_IN),
    .PIPE_HOLD(PIPE_HOLD), .INIT_DONE(INIT_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_state(input string tag);
    check({tag, "_write"}, {31'd0, RF_WRITE}, 32'd1);
    check({tag, "_addr"}, {27'd0, RF_INADDRESS}, 32'd0);
    check({tag, "_in"}, RF_IN, 32'd0);
    check({tag, "_hold"}, {31'd0, PIPE_HOLD}, 32'd1);
    check({tag, "_ready"}, {31'd0, MD_READY}, 32'd0);
    check({tag, "_done"}, {31'd0, INIT_DONE}, 32'd0);
    check({tag, "_busy"}, BUSY_MASK, 32'd0);
  endtask

  // walks n clear cycles starting at register 0; ISSUE is driven to show it is ignored
  task automatic clear_walk(input int n, input logic issue);
    for (int i = 0; i < n; i++) begin
      ISSUE_VALID = issue && i < 31;
      ISSUE_ADDR = 5'd6;
      #1;
      check($sformatf("clr%0d_write", i), {31'd0, RF_WRITE}, 32'd1);
      check($sformatf("clr%0d_addr", i), {27'd0, RF_INADDRESS}, i);
      check($sformatf("clr%0d_in", i), RF_IN, 32'd0);
      check($sformatf("clr%0d_flags", i), {29'd0, PIPE_HOLD, MD_READY, INIT_DONE}, 32'b100);
      check($sformatf("clr%0d_busy", i), BUSY_MASK, 32'd0);
      tick;
    end
    ISSUE_VALID = 0;
  endtask

  initial begin
    #12;
    reset_state("rst");
    RESET = 1;
    clear_walk(32, 1'b0);
    #1;
    check("run_done", {31'd0, INIT_DONE}, 32'd1);
    check("run_hold", {31'd0, PIPE_HOLD}, 32'd0);
    check("run_idle_write", {31'd0, RF_WRITE}, 32'd0);
    check("run_busy", BUSY_MASK, 32'd0);

    // WB beats MD, MD follows once WB goes idle
    WB_VALID = 1; WB_ADDR = 5; WB_DATA = 32'hDEADBEEF;
    MD_VALID = 1; MD_ADDR = 7; MD_DATA = 32'h77;
    #1;
    check("pri_addr", {27'd0, RF_INADDRESS}, 32'd5);
    check("pri_in", RF_IN, 32'hDEADBEEF);
    check("pri_ready", {31'd0, MD_READY}, 32'd0);
    check("pri_write", {31'd0, RF_WRITE}, 32'd1);
    tick;
    WB_VALID = 0;
    #1;
    check("md_addr", {27'd0, RF_INADDRESS}, 32'd7);
    check("md_in", RF_IN, 32'h77);
    check("md_ready", {31'd0, MD_READY}, 32'd1);
    check("md_write", {31'd0, RF_WRITE}, 32'd1);
    tick;
    MD_VALID = 0;

    // starvation: 3 blocked cycles, then forced MD win
    WB_VALID = 1; WB_ADDR = 3; WB_DATA = 32'h33;
    MD_VALID = 1; MD_ADDR = 9; MD_DATA = 32'h99;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("stv%0d_addr", i), {27'd0, RF_INADDRESS}, 32'd3);
      check($sformatf("stv%0d_rh", i), {30'd0, MD_READY, PIPE_HOLD}, 32'b00);
      tick;
    end
    #1;
    check("stv3_hold", {31'd0, PIPE_HOLD}, 32'd1);
    check("stv3_addr", {27'd0, RF_INADDRESS}, 32'd9);
    check("stv3_in", RF_IN, 32'h99);
    check("stv3_ready", {31'd0, MD_READY}, 32'd1);
    tick;
    MD_VALID = 0;
    #1;
    check("stv4_hold", {31'd0, PIPE_HOLD}, 32'd0);
    check("stv4_addr", {27'd0, RF_INADDRESS}, 32'd3);
    check("stv4_in", RF_IN, 32'h33);
    tick;

    // ineffective requests
    WB_ADDR = 0; MD_VALID = 1; MD_ADDR = 4; MD_DATA = 32'h44;
    #1;
    check("wb0_write", {31'd0, RF_WRITE}, 32'd1);
    check("wb0_addr", {27'd0, RF_INADDRESS}, 32'd4);
    check("wb0_ready", {31'd0, MD_READY}, 32'd1);
    tick;
    WB_VALID = 0; MD_ADDR = 0;
    #1;
    check("md0_ready", {31'd0, MD_READY}, 32'd1);
    check("md0_write", {31'd0, RF_WRITE}, 32'd0);
    tick;
    MD_VALID = 0;

    // scoreboard
    ISSUE_VALID = 1; ISSUE_ADDR = 10;
    tick;
    check("sb_set", BUSY_MASK, 32'h400);
    MD_VALID = 1; MD_ADDR = 10;
    tick;
    check("sb_setwins", BUSY_MASK, 32'h400);
    ISSUE_ADDR = 12; MD_VALID = 0;
    tick;
    check("sb_set12", BUSY_MASK, 32'h1400);
    ISSUE_VALID = 0; MD_VALID = 1; MD_ADDR = 10;
    tick;
    check("sb_clr10", BUSY_MASK, 32'h1000);
    MD_ADDR = 12;
    tick;
    MD_VALID = 0; ISSUE_VALID = 1; ISSUE_ADDR = 0;
    tick;
    check("sb_x0", BUSY_MASK, 32'd0);
    ISSUE_ADDR = 5;
    tick;
    ISSUE_VALID = 0;
    check("sb_set5", BUSY_MASK, 32'h20);

    // reset mid-RUN, then mid-CLEAR at counter 17
    #2;
    RESET = 0;
    #1;
    reset_state("rrun");
    #1;
    RESET = 1;
    clear_walk(17, 1'b0);
    RESET = 0;
    #1;
    reset_state("rclr");
    RESET = 1;
    clear_walk(32, 1'b1);
    #1;
    check("rclr_done", {31'd0, INIT_DONE}, 32'd1);
    check("rclr_busy", BUSY_MASK, 32'd0);
    check("rclr_hold", {31'd0, PIPE_HOLD}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 registers by 32 bits.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset; RESET=0 forces the reset state immediately, independent of CLK.
REQ-004 WB_VALID / WB_ADDR / WB_DATA  input  1/5/32  pipeline writeback request; it has no handshake and is sampled only when PIPE_HOLD=0.
REQ-005 MD_VALID / MD_ADDR / MD_DATA  input  1/5/32  MUL/DIV unit result request.
REQ-006 MD_READY  output  1  MUL/DIV result accepted this cycle when MD_VALID=1.
REQ-007 ISSUE_VALID / ISSUE_ADDR  input  1/5  MUL/DIV operation issued with destination ISSUE_ADDR.
REQ-008 BUSY_MASK  output  32  scoreboard; bit n=1 means register xn has a pending MUL/DIV result.
REQ-009 RF_WRITE / RF_INADDRESS / RF_IN  output  1/5/32  register-file write port (WRITE, INADDRESS, IN).
REQ-010 PIPE_HOLD  output  1  pipeline SHALL freeze its WB stage and re-present the same request next cycle.
REQ-011 INIT_DONE  output  1  register-file clear sequence complete.

Function
REQ-012 The state machine SHALL have two states, CLEAR and RUN; the CLEAR->RUN transition SHALL occur when the clear counter is 31 and advances; RUN SHALL be held until reset.
REQ-013 In CLEAR, the block SHALL drive RF_WRITE=1, RF_INADDRESS=clear counter, RF_IN=0, with the counter incrementing 0..31 once per cycle, so that exactly 32 write cycles occur.
REQ-014 In CLEAR, PIPE_HOLD=1, MD_READY=0, INIT_DONE=0, and ISSUE_VALID SHALL be ignored.
REQ-015 In RUN, INIT_DONE SHALL be 1.
REQ-016 In RUN, RF_* outputs SHALL be combinational from the winning request (zero-cycle latency); the register file commits the write on the same CLK edge.
REQ-017 A request is "effective" only when its valid is 1 and its address is nonzero.
REQ-018 Ineffective requests SHALL never assert RF_WRITE.
REQ-019 An MD request to address 0 SHALL still be accepted (MD_READY=1) and discarded.
REQ-020 Priority (RUN, PIPE_HOLD=0): an effective WB request SHALL win; MD_READY=0 whenever an effective WB request is present, otherwise MD_READY=1.
REQ-021 A 2-bit starvation counter SHALL increment each cycle with MD_VALID=1 and MD_READY=0, and SHALL saturate at 3.
REQ-022 The starvation counter SHALL clear on every MD acceptance.
REQ-023 In RUN, PIPE_HOLD SHALL be combinationally 1 exactly when the starvation counter is 3.
REQ-024 While PIPE_HOLD=1 in RUN, WB SHALL be ignored and MD SHALL win the port (MD_READY=1), bounding MD wait to 3 cycles.
REQ-025 Scoreboard: in RUN, ISSUE_VALID with ISSUE_ADDR!=0 SHALL set that BUSY_MASK bit on the next edge.
REQ-026 Scoreboard: MD acceptance SHALL clear the BUSY_MASK bit for MD_ADDR on the next edge.
REQ-027 If set and clear target the same register in the same cycle, set SHALL win.
REQ-028 BUSY_MASK bit 0 SHALL always read 0.
REQ-029 Issuing to an already-busy register SHALL leave its bit set; no error is flagged.
REQ-030 Simultaneous effective WB and MD writes to the same address SHALL resolve per REQ-020 and REQ-024; the loser's data SHALL be written in a later cycle, never merged.

Reset
REQ-031 On RESET=0: state=CLEAR, clear counter=0, starvation counter=0, BUSY_MASK=0, INIT_DONE=0, PIPE_HOLD=1, MD_READY=0.
REQ-032 During reset, RF_WRITE=1, RF_INADDRESS=0, RF_IN=0.
REQ-033 Reset asserted mid-CLEAR or mid-RUN SHALL abort all activity and, after release, restart the full 32-cycle clear from register 0.
REQ-034 An MD result not yet accepted when reset asserts SHALL be lost; MD_READY SHALL stay 0 until RUN.

Verification
REQ-035 Release RESET, idle inputs -> RF_WRITE=1 for 32 cycles with RF_INADDRESS 0..31 and RF_IN=0; INIT_DONE=1 and PIPE_HOLD=0 on cycle 33.
REQ-036 RUN: WB_VALID=1, WB_ADDR=5, WB_DATA=0xDEADBEEF with MD_VALID=1, MD_ADDR=7 -> RF_INADDRESS=5, MD_READY=0; next cycle, with WB idle, RF_INADDRESS=7 and MD_READY=1.
REQ-037 Continuous effective WB (addr 3) with MD_VALID=1 (addr 9) -> MD blocked 3 cycles; 4th cycle PIPE_HOLD=1, RF_INADDRESS=9, MD_READY=1; following cycle PIPE_HOLD=0 and WB resumes.
REQ-038 WB_ADDR=0 with MD_VALID=1, MD_ADDR=4 -> RF_WRITE for address 4 only, MD_READY=1; MD_ADDR=0 alone -> MD_READY=1, RF_WRITE=0.
REQ-039 ISSUE x10, then same-cycle ISSUE x10 and MD accept x10 -> BUSY_MASK[10] stays 1; a later accept-only -> BUSY_MASK[10]=0; ISSUE x0 -> BUSY_MASK=0.
REQ-040 Assert RESET at clear counter 17, release -> clear restarts at address 0 and completes 32 writes; BUSY_MASK=0 throughout.
